// File: rtl/div_seq.sv
// div_seq: multi-cycle restoring divider for the EX stage.
// Produces {remainder, quotient} one quotient bit per cycle, with optional
// signed operation handled by magnitude division plus final sign correction.
module div_seq #(
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  signed_div_i,
    input  logic [DATA_W-1:0]     opdata1_i,
    input  logic [DATA_W-1:0]     opdata2_i,
    input  logic                  start_i,
    input  logic                  annul_i,
    output logic [2*DATA_W-1:0]   result_o,
    output logic                  ready_o,
    output logic                  busy_o
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BYZERO,
        ST_ON,
        ST_END
    } state_t;

    localparam logic [5:0] LAST_ITER = 6'(DATA_W - 1);

    state_t                state_q, state_d;
    logic [5:0]            cnt_q, cnt_d;
    // Dividend bits are shifted out of the top while quotient bits enter at the bottom.
    logic [DATA_W-1:0]     dq_q, dq_d;
    logic [DATA_W-1:0]     rem_q, rem_d;
    logic [DATA_W-1:0]     dsr_q, dsr_d;
    logic                  neg_quot_q, neg_quot_d;
    logic                  neg_rem_q, neg_rem_d;
    logic [2*DATA_W-1:0]   result_q, result_d;
    logic                  ready_q, ready_d;

    // One restoring step: compare needs one extra bit for the shifted remainder.
    logic [DATA_W:0]       shifted;
    logic [DATA_W:0]       diff;
    logic                  q_bit;
    logic [DATA_W-1:0]     rem_next;
    logic [DATA_W-1:0]     quot_next;
    logic                  op1_neg;
    logic                  op2_neg;

    // Iteration datapath and next-state / output decode.
    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        state_d    = state_q;
        cnt_d      = cnt_q;
        dq_d       = dq_q;
        rem_d      = rem_q;
        dsr_d      = dsr_q;
        neg_quot_d = neg_quot_q;
        neg_rem_d  = neg_rem_q;
        result_d   = result_q;
        ready_d    = ready_q;

        shifted   = {rem_q, dq_q[DATA_W-1]};
        diff      = shifted - {1'b0, dsr_q};
        q_bit     = ~diff[DATA_W];
        rem_next  = q_bit ? diff[DATA_W-1:0] : shifted[DATA_W-1:0];
        quot_next = {dq_q[DATA_W-2:0], q_bit};

        op1_neg = signed_div_i & opdata1_i[DATA_W-1];
        op2_neg = signed_div_i & opdata2_i[DATA_W-1];

        unique case (state_q)
            ST_IDLE: begin
                if (start_i && !annul_i) begin
                    dq_d       = op1_neg ? -opdata1_i : opdata1_i;
                    dsr_d      = op2_neg ? -opdata2_i : opdata2_i;
                    rem_d      = '0;
                    cnt_d      = '0;
                    neg_rem_d  = op1_neg;
                    neg_quot_d = op1_neg ^ op2_neg;
                    state_d    = (opdata2_i == '0) ? ST_BYZERO : ST_ON;
                end
            end
            ST_BYZERO: begin
                result_d = '0;
                if (annul_i) begin
                    ready_d = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    ready_d = 1'b1;
                    state_d = ST_END;
                end
            end
            ST_ON: begin
                if (annul_i) begin
                    result_d = '0;
                    ready_d  = 1'b0;
                    cnt_d    = '0;
                    state_d  = ST_IDLE;
                end else begin
                    rem_d = rem_next;
                    dq_d  = quot_next;
                    cnt_d = cnt_q + 6'd1;
                    if (cnt_q == LAST_ITER) begin
                        result_d = {neg_rem_q  ? -rem_next  : rem_next,
                                    neg_quot_q ? -quot_next : quot_next};
                        ready_d  = 1'b1;
                        cnt_d    = '0;
                        state_d  = ST_END;
                    end
                end
            end
            ST_END: begin
                // Result is held until EX drops its request; annul has no effect here.
                if (!start_i) begin
                    result_d = '0;
                    ready_d  = 1'b0;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, counter, datapath and registered outputs; reset clears everything at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            dq_q       <= '0;
            rem_q      <= '0;
            dsr_q      <= '0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            result_q   <= '0;
            ready_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            dq_q       <= dq_d;
            rem_q      <= rem_d;
            dsr_q      <= dsr_d;
            neg_quot_q <= neg_quot_d;
            neg_rem_q  <= neg_rem_d;
            result_q   <= result_d;
            ready_q    <= ready_d;
        end
    end

    assign result_o = result_q;
    assign ready_o  = ready_q;
    assign busy_o   = (state_q == ST_BYZERO) || (state_q == ST_ON);

endmodule

// File: tb/tb_div_seq.sv
// tb_div_seq: scenario-driven bench for div_seq with an expected-result queue.
module tb_div_seq;

    localparam int W = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            signed_div_i;
    logic [W-1:0]    opdata1_i;
    logic [W-1:0]    opdata2_i;
    logic            start_i;
    logic            annul_i;
    logic [2*W-1:0]  result_o;
    logic            ready_o;
    logic            busy_o;

    int n_checks = 0;
    int n_fail   = 0;
    logic [2*W-1:0] exp_q[$];

    div_seq #(.DATA_W(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o),
        .busy_o       (busy_o)
    );

    always #5 clk = ~clk;

    // Reference divide: truncating division, remainder takes the dividend's sign,
    // computed in 64 bits so the most-negative / -1 case wraps naturally.
    function automatic logic [2*W-1:0] model(input logic sgn, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
        longint sa, sb, q, r;
        logic [63:0] ua, ub, uq, ur;
        if (b == '0) return '0;
        if (sgn) begin
            sa = longint'(signed'(a));
            sb = longint'(signed'(b));
            q  = sa / sb;
            r  = sa % sb;
            return {r[W-1:0], q[W-1:0]};
        end
        ua = {32'b0, a};
        ub = {32'b0, b};
        uq = ua / ub;
        ur = ua % ub;
        return {ur[W-1:0], uq[W-1:0]};
    endfunction

    // Full request: push expectation, wait for ready with a bound, check latency,
    // busy, result, END hold, and the return to idle. Entered 1ns after an edge.
    task automatic run_div(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [2*W-1:0] expv, input int exp_lat, input string name);
        int lat;
        int busy_bad;
        logic [2*W-1:0] e;
        exp_q.push_back(expv);
        signed_div_i = sgn;
        opdata1_i    = a;
        opdata2_i    = b;
        start_i      = 1'b1;
        @(posedge clk); #1;
        // Operands change after acceptance and must not matter.
        opdata1_i    = $urandom;
        opdata2_i    = $urandom;
        signed_div_i = ~sgn;
        lat = 0;
        busy_bad = 0;
        while (!ready_o && lat < 100) begin
            if (!busy_o) busy_bad++;
            @(posedge clk); #1;
            lat++;
        end
        n_checks++;
        if (lat !== exp_lat) begin
            n_fail++;
            $display("FAIL %s latency: got %0d expected %0d", name, lat, exp_lat);
        end
        n_checks++;
        if (busy_bad !== 0) begin
            n_fail++;
            $display("FAIL %s busy: low for %0d cycles while in flight, expected 0", name, busy_bad);
        end
        e = exp_q.pop_front();
        if (ready_o) begin
            n_checks++;
            if (result_o !== e) begin
                n_fail++;
                $display("FAIL %s result: got %h expected %h", name, result_o, e);
            end
            n_checks++;
            if (busy_o !== 1'b0) begin
                n_fail++;
                $display("FAIL %s busy_done: got %b expected 0", name, busy_o);
            end
            @(posedge clk); #1;
            n_checks++;
            if (ready_o !== 1'b1 || result_o !== e) begin
                n_fail++;
                $display("FAIL %s end_hold: got ready=%b result=%h expected ready=1 result=%h",
                         name, ready_o, result_o, e);
            end
            start_i = 1'b0;
            @(posedge clk); #1;
            n_checks++;
            if (ready_o !== 1'b0 || result_o !== '0 || busy_o !== 1'b0) begin
                n_fail++;
                $display("FAIL %s to_idle: got ready=%b busy=%b result=%h expected all 0",
                         name, ready_o, busy_o, result_o);
            end
        end else begin
            start_i = 1'b0;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset;
        rst          = 1'b0;
        start_i      = 1'b0;
        annul_i      = 1'b0;
        signed_div_i = 1'b0;
        opdata1_i    = '0;
        opdata2_i    = '0;
        @(posedge clk); #1;
        n_checks++;
        if (ready_o !== 1'b0 || busy_o !== 1'b0 || result_o !== '0) begin
            n_fail++;
            $display("FAIL reset_state: got ready=%b busy=%b result=%h expected all 0",
                     ready_o, busy_o, result_o);
        end
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_unsigned;
        run_div(1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 32, "u_100_7");
        run_div(1'b0, 32'hFFFFFFFF, 32'd1, {32'h0, 32'hFFFFFFFF}, 32, "u_max_1");
        run_div(1'b0, 32'd3, 32'hFFFFFFFF, {32'd3, 32'h0}, 32, "u_3_max");
    endtask

    task automatic test_signed;
        run_div(1'b1, 32'hFFFFFFF9, 32'h2, {32'hFFFFFFFF, 32'hFFFFFFFD}, 32, "s_m7_2");
        run_div(1'b1, 32'h7, 32'hFFFFFFFE, {32'h1, 32'hFFFFFFFD}, 32, "s_7_m2");
        run_div(1'b1, 32'h80000000, 32'hFFFFFFFF, {32'h0, 32'h80000000}, 32, "s_min_m1");
    endtask

    task automatic test_random;
        logic [W-1:0] a, b;
        logic sgn;
        for (int i = 0; i < 6; i++) begin
            a   = $urandom;
            b   = $urandom >> $urandom_range(0, 28);
            if (b == '0) b = 32'd5;
            sgn = i[0];
            run_div(sgn, a, b, model(sgn, a, b), 32, "random");
        end
    endtask

    task automatic test_div_zero;
        run_div(1'b0, 32'd12345, 32'd0, '0, 1, "u_by_zero");
        run_div(1'b1, 32'hFFFF0000, 32'd0, '0, 1, "s_by_zero");
    endtask

    // Request and annul together in IDLE must be ignored.
    task automatic test_idle_annul;
        int busy_seen;
        busy_seen = 0;
        signed_div_i = 1'b0;
        opdata1_i    = 32'd40;
        opdata2_i    = 32'd4;
        start_i      = 1'b1;
        annul_i      = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            if (busy_o || ready_o) busy_seen++;
        end
        n_checks++;
        if (busy_seen !== 0) begin
            n_fail++;
            $display("FAIL idle_annul: got %0d active cycles expected 0", busy_seen);
        end
        start_i = 1'b0;
        annul_i = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_annul;
        int lat;
        int ready_seen;
        signed_div_i = 1'b0;
        opdata1_i    = 32'd1000;
        opdata2_i    = 32'd3;
        start_i      = 1'b1;
        @(posedge clk); #1;
        lat = 0;
        while (lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        annul_i = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (busy_o !== 1'b0 || ready_o !== 1'b0 || result_o !== '0) begin
            n_fail++;
            $display("FAIL annul_idle: got busy=%b ready=%b result=%h expected all 0",
                     busy_o, ready_o, result_o);
        end
        start_i = 1'b0;
        annul_i = 1'b0;
        ready_seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (ready_o || busy_o) ready_seen++;
        end
        n_checks++;
        if (ready_seen !== 0) begin
            n_fail++;
            $display("FAIL annul_quiet: got %0d active cycles expected 0", ready_seen);
        end
        run_div(1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 32, "after_annul");
    endtask

    task automatic test_reset_mid;
        int lat;
        signed_div_i = 1'b0;
        opdata1_i    = 32'd1234;
        opdata2_i    = 32'd7;
        start_i      = 1'b1;
        @(posedge clk); #1;
        lat = 0;
        while (lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        n_checks++;
        if (busy_o !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_busy: got %b expected 1", busy_o);
        end
        #2;
        rst     = 1'b0;
        start_i = 1'b0;
        #1;
        n_checks++;
        if (busy_o !== 1'b0 || ready_o !== 1'b0 || result_o !== '0) begin
            n_fail++;
            $display("FAIL async_reset_mid: got busy=%b ready=%b result=%h expected all 0",
                     busy_o, ready_o, result_o);
        end
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        run_div(1'b0, 32'd50, 32'd5, {32'd0, 32'd10}, 32, "after_reset");
    endtask

    // Reset while a finished result is being held must clear it without an edge.
    task automatic test_reset_end;
        int lat;
        logic [2*W-1:0] e;
        exp_q.push_back(model(1'b0, 32'd100, 32'd9));
        signed_div_i = 1'b0;
        opdata1_i    = 32'd100;
        opdata2_i    = 32'd9;
        start_i      = 1'b1;
        @(posedge clk); #1;
        lat = 0;
        while (!ready_o && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        e = exp_q.pop_front();
        n_checks++;
        if (ready_o !== 1'b1 || result_o !== e) begin
            n_fail++;
            $display("FAIL end_result: got ready=%b result=%h expected ready=1 result=%h",
                     ready_o, result_o, e);
        end
        #2;
        rst     = 1'b0;
        start_i = 1'b0;
        #1;
        n_checks++;
        if (ready_o !== 1'b0 || result_o !== '0) begin
            n_fail++;
            $display("FAIL async_reset_end: got ready=%b result=%h expected 0",
                     ready_o, result_o);
        end
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back;
        run_div(1'b0, 32'd81, 32'd9, {32'd0, 32'd9}, 32, "b2b_first");
        run_div(1'b1, 32'hFFFFFF9C, 32'd7, model(1'b1, 32'hFFFFFF9C, 32'd7), 32, "b2b_second");
    endtask

    initial begin
        test_reset;
        test_unsigned;
        test_signed;
        test_div_zero;
        test_idle_annul;
        test_annul;
        test_reset_mid;
        test_reset_end;
        test_back_to_back;
        test_random;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
